// File: rtl/edge_pkg.sv
// Shared types for the edge-detect output writer: pixel formats, frame FSM
// states and small helpers.
package edge_pkg;

  typedef logic [23:0] rgb_t;
  typedef logic [7:0]  gray_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_LAST,
    S_DONE
  } frame_state_e;

  // Replicate one gray level into all three colour channels.
  function automatic rgb_t gray2rgb(input gray_t g);
    return {g, g, g};
  endfunction

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_frame_writer_if.sv
// FIFO-side signals of the frame writer: the 8-bit source FIFO it drains and
// the 24-bit sink FIFO it fills.
interface edge_frame_writer_if;
  import edge_pkg::*;

  logic  in_rd_en;
  logic  in_empty;
  gray_t in_dout;
  logic  out_wr_en;
  logic  out_full;
  rgb_t  out_din;
  logic  out_sof;
  logic  out_eol;

  // Writer side.
  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din,
    output out_sof,
    output out_eol
  );

  // FIFO side.
  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din,
    input  out_sof,
    input  out_eol
  );

endinterface

// File: rtl/pix_pos_counter.sv
// Raster position counter: x runs 0..WIDTH-1, y advances on each x wrap and
// runs 0..HEIGHT-1. Flags describe the position of the next pixel to pop.
module pix_pos_counter
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 540,
  localparam int unsigned XW    = cnt_width(WIDTH),
  localparam int unsigned YW    = cnt_width(HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          is_first,
  output logic          is_eol,
  output logic          is_last
);

  localparam logic [XW-1:0] XMax = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMax = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Step through the raster once per advance, wrapping at the frame end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clear) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance) begin
      if (x_q == XMax) begin
        x_q <= '0;
        y_q <= (y_q == YMax) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign is_first = (x_q == '0) && (y_q == '0);
  assign is_eol   = (x_q == XMax);
  assign is_last  = (x_q == XMax) && (y_q == YMax);

endmodule

// File: rtl/edge_frame_writer.sv
// Drains the 8-bit Sobel result FIFO into a 24-bit RGB FIFO through a
// one-entry hold register, tagging start-of-frame / end-of-line and counting
// completed frames.
module edge_frame_writer
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 540,
  parameter gray_t       THRESH = 8'd64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bin_en,
  edge_frame_writer_if.master  bus,
  output logic                 frame_done,
  output logic [15:0]          frame_count
);

  localparam int unsigned XW = cnt_width(WIDTH);
  localparam int unsigned YW = cnt_width(HEIGHT);
  localparam logic [XW-1:0] XMax = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMax = YW'(HEIGHT - 1);

  frame_state_e state_q, state_d;

  logic        hold_valid_q;
  rgb_t        hold_data_q;
  logic        hold_sof_q;
  logic        hold_eol_q;
  logic [15:0] frame_count_q;

  logic          pop;
  logic          write;
  gray_t         pix;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          is_first;
  logic          is_eol;
  logic          is_last;

  // A write frees the hold register, so a pop may refill it in the same cycle.
  // Reset gates the pop so the source FIFO is never read while held in reset.
  assign write = hold_valid_q && !bus.out_full;
  assign pop   = reset && (state_q == S_RUN) && !bus.in_empty &&
                 (!hold_valid_q || !bus.out_full);

  assign pix = bin_en ? ((bus.in_dout >= THRESH) ? 8'hFF : 8'h00) : bus.in_dout;

  pix_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clock    (clock),
    .reset    (reset),
    .advance  (pop),
    .clear    (state_q == S_DONE),
    .x        (x),
    .y        (y),
    .is_first (is_first),
    .is_eol   (is_eol),
    .is_last  (is_last)
  );

  // Hold register: load on pop, empty on a write that is not refilled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_sof_q   <= 1'b0;
      hold_eol_q   <= 1'b0;
    end else if (pop) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= gray2rgb(pix);
      hold_sof_q   <= is_first;
      hold_eol_q   <= is_eol;
    end else if (write) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Frame state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: stop popping after the last pixel until it is written.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      S_RUN: begin
        if (pop && is_last) state_d = S_LAST;
      end
      S_LAST: begin
        if (write) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Completed-frame counter, wraps naturally at 2^16.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
    end else if (state_q == S_DONE) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count   = frame_count_q;
  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = write;
  assign bus.out_din   = hold_data_q;
  assign bus.out_sof   = hold_sof_q;
  assign bus.out_eol   = hold_eol_q;

  // Position flags must agree with the raw coordinates.
  assert property (@(posedge clock) disable iff (!reset)
    (is_eol == (x == XMax)) && (is_last == ((x == XMax) && (y == YMax))) &&
    (is_first == ((x == '0) && (y == '0))));

endmodule

// File: tb/tb_edge_frame_writer.sv
// Randomized bench for edge_frame_writer (4x2 frame) against a queue-based
// model of the source FIFO, the expected pixel stream and frame accounting.
module tb_edge_frame_writer;
  import edge_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned N  = W * H;
  localparam logic [7:0]  TH = 8'd64;

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        last;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        bin_en = 1'b0;
  logic        frame_done;
  logic [15:0] frame_count;

  edge_frame_writer_if bus ();

  edge_frame_writer #(
    .WIDTH  (W),
    .HEIGHT (H),
    .THRESH (TH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bin_en      (bin_en),
    .bus         (bus),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  logic [7:0] src_q[$];
  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         pop_idx = 0;
  int         frames_m = 0;
  bit         blocked = 1'b0;
  bit         done_due = 1'b0;
  int         done_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] expect_pix(input logic [7:0] b, input bit ben);
    logic [7:0] p;
    p = ben ? ((b >= TH) ? 8'hFF : 8'h00) : b;
    return 24'(p) * 24'h010101;
  endfunction

  // One clock: drive inputs, check at negedge, advance the model at posedge.
  task automatic cycle(input bit gate, input bit full, input bit ben);
    bit         rd;
    bit         wr;
    exp_t       e;
    logic [7:0] b;
    bus.in_empty = gate || (src_q.size() == 0);
    bus.in_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    bus.out_full = full;
    bin_en       = ben;
    @(negedge clock);
    if (frame_done) done_pulses++;
    check_eq("frame_done", frame_done, done_due);
    check_eq("frame_count", frame_count, 32'(frames_m[15:0]));
    check_eq("out_wr_en", bus.out_wr_en, (exp_q.size() != 0) && !full);
    check_eq("in_rd_en", bus.in_rd_en,
             !blocked && !bus.in_empty && ((exp_q.size() == 0) || !full));
    if (exp_q.size() != 0) begin
      check_eq("out_din", bus.out_din, exp_q[0].data);
      if (bus.out_wr_en) begin
        check_eq("out_sof", bus.out_sof, exp_q[0].sof);
        check_eq("out_eol", bus.out_eol, exp_q[0].eol);
      end
    end
    rd = bus.in_rd_en;
    wr = bus.out_wr_en;
    @(posedge clock);
    if (done_due) begin
      frames_m++;
      blocked = 1'b0;
    end
    done_due = 1'b0;
    if (wr && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.last) done_due = 1'b1;
    end
    if (rd && src_q.size() != 0) begin
      b = src_q.pop_front();
      e.data = expect_pix(b, ben);
      e.sof  = (pop_idx == 0);
      e.eol  = ((pop_idx % W) == W - 1);
      e.last = (pop_idx == N - 1);
      exp_q.push_back(e);
      if (pop_idx == N - 1) begin
        blocked = 1'b1;
        pop_idx = 0;
      end else begin
        pop_idx++;
      end
    end
    #1;
  endtask

  // Run until source, hold and frame sequencing are idle (bounded).
  task automatic drain(input int gate_pct, input int full_pct, input int ben_mode);
    int budget;
    bit ben;
    budget = 4000;
    while ((src_q.size() != 0 || exp_q.size() != 0 || done_due || blocked) && budget > 0) begin
      ben = (ben_mode == 2) ? bit'($urandom_range(1)) : bit'(ben_mode);
      cycle($urandom_range(99) < gate_pct, $urandom_range(99) < full_pct, ben);
      budget--;
    end
    check_eq("drain_timeout", 32'(budget == 0), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr"}, bus.out_wr_en, 1'b0);
    check_eq({tag, "_din"}, bus.out_din, 24'h0);
    check_eq({tag, "_sof"}, bus.out_sof, 1'b0);
    check_eq({tag, "_eol"}, bus.out_eol, 1'b0);
    check_eq({tag, "_rd"}, bus.in_rd_en, 1'b0);
    check_eq({tag, "_done"}, frame_done, 1'b0);
    check_eq({tag, "_cnt"}, frame_count, 16'h0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pop_idx  = 0;
    frames_m = 0;
    blocked  = 1'b0;
    done_due = 1'b0;
  endtask

  initial begin
    int pulses0;
    int pad;
    bus.in_empty = 1'b1;
    bus.in_dout  = 8'h00;
    bus.out_full = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Preloaded frame at full rate.
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
    drain(0, 0, 0);
    check_eq("frames_after_first", frame_count, 16'd1);

    // Binarization around the threshold.
    src_q.push_back(8'd63);
    src_q.push_back(8'd64);
    src_q.push_back(8'd200);
    src_q.push_back(8'd0);
    drain(0, 0, 1);

    // Backpressure: hold one pixel while the sink is full for five cycles.
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    cycle(0, 0, 0);
    repeat (5) cycle(0, 1, 0);
    drain(0, 0, 0);

    // Starvation: source empty every other cycle.
    for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
    for (int i = 0; i < 40; i++) cycle(i % 2 == 1, 0, 0);
    drain(50, 0, 0);

    // Random mix of starvation, backpressure and bin_en.
    for (int i = 0; i < 300; i++) src_q.push_back(8'($urandom));
    drain(40, 30, 2);

    // Asynchronous reset mid-frame.
    pad = int'((N - pop_idx) % N);
    for (int i = 0; i < pad; i++) src_q.push_back(8'($urandom));
    drain(0, 0, 0);
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    repeat (3) cycle(0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drain(0, 0, 0);
    check_eq("frames_after_rst", frame_count, 32'(frames_m[15:0]));

    // Three back-to-back frames at full rate.
    pad = int'((N - pop_idx) % N);
    for (int i = 0; i < pad; i++) src_q.push_back(8'($urandom));
    drain(0, 0, 0);
    pulses0 = done_pulses;
    frames_m = int'(frame_count);
    for (int i = 0; i < 3 * N; i++) src_q.push_back(8'($urandom));
    drain(0, 0, 2);
    check_eq("three_frame_pulses", done_pulses - pulses0, 32'd3);
    check_eq("three_frame_count", frame_count, 32'(frames_m[15:0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
